cdb_arbiter: RTL and testbench

Transmitter side of the common data bus. Buffers completed results from the ALU and from the load path in two small FIFOs, then arbitrates one result per cycle onto the CDB. The CDB is consumed by the reorder buffer and the reservation stations. The block sits between the execution units (ALU, d-cache load return) and every CDB listener, and it is cleared on branch-mispredict flush.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_if.sv | 38 +++
 rtl/cdb_fifo.sv | 63 ++++++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared types and widths for the CDB transmitter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    // Core-wide widths (mirror the global ROB/datapath sizing)
    localparam int ROB_DEPTH_BITS = 7;
    localparam int DATA_WIDTH     = 32;

    // Which execution source produced the current broadcast
    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LD  = 1'b1
    } CdbSource;

    // One buffered completion waiting for the bus
    typedef struct packed {
        logic [ROB_DEPTH_BITS-1:0] tag;
        logic [DATA_WIDTH-1:0]     data;
    } cdb_entry_t;

    localparam int ENTRY_WIDTH = $bits(cdb_entry_t);

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Execution-unit result inputs and CDB broadcast outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                      flush;
    logic                      alu_valid;
    logic [ROB_DEPTH_BITS-1:0] alu_tag;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      ld_valid;
    logic [ROB_DEPTH_BITS-1:0] ld_tag;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      alu_full;
    logic                      ld_full;
    logic                      cdb_valid;
    logic [ROB_DEPTH_BITS-1:0] cdb_tag;
    logic [DATA_WIDTH-1:0]     cdb_data;
    CdbSource                  cdb_src;
    logic                      overflow_err;

    // Producer side: execution units, flush source and CDB listeners
    modport master (
        output flush, alu_valid, alu_tag, alu_result, ld_valid, ld_tag, ld_data,
        input  alu_full, ld_full, cdb_valid, cdb_tag, cdb_data, cdb_src, overflow_err
    );

    // Arbiter side
    modport slave (
        input  flush, alu_valid, alu_tag, alu_result, ld_valid, ld_tag, ld_data,
        output alu_full, ld_full, cdb_valid, cdb_tag, cdb_data, cdb_src, overflow_err
    );

endinterface
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_fifo
//  Description : Small synchronous FIFO with registered count and clear.
//                Read data is the head entry, valid whenever !empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Pushes while full are dropped; a clear discards everything presented
    assign do_push = push && !full  && !clear;
    assign do_pop  = pop  && !empty && !clear;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Buffers ALU and load completions and broadcasts one per
//                cycle on the common data bus with round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    cdb_arbiter_if.slave  bus
);
    cdb_entry_t alu_head;
    cdb_entry_t ld_head;
    logic       alu_empty;
    logic       ld_empty;
    logic       alu_full;
    logic       ld_full;
    logic       grant_alu;
    logic       grant_ld;

    CdbSource                  last_grant;
    logic                      cdb_valid;
    logic [ROB_DEPTH_BITS-1:0] cdb_tag;
    logic [DATA_WIDTH-1:0]     cdb_data;
    CdbSource                  cdb_src;
    logic                      overflow_err;

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_WIDTH)) u_alu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.alu_valid),
        .pop   (grant_alu),
        .clear (bus.flush),
        .din   ({bus.alu_tag, bus.alu_result}),
        .dout  (alu_head),
        .empty (alu_empty),
        .full  (alu_full)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_WIDTH)) u_ld_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.ld_valid),
        .pop   (grant_ld),
        .clear (bus.flush),
        .din   ({bus.ld_tag, bus.ld_data}),
        .dout  (ld_head),
        .empty (ld_empty),
        .full  (ld_full)
    );

    // Round-robin on registered FIFO state: a lone requester always wins,
    // on a tie the source that did not win last time goes
    always_comb begin
        grant_alu = !alu_empty && (ld_empty  || (last_grant == CDB_SRC_LD));
        grant_ld  = !ld_empty  && (alu_empty || (last_grant == CDB_SRC_ALU));
    end

    // CDB output register and arbitration history; flush clears the bus
    // but leaves the fairness pointer where it was
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_src    <= CDB_SRC_ALU;
            last_grant <= CDB_SRC_LD;
        end else if (bus.flush) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_src    <= CDB_SRC_ALU;
        end else if (grant_alu) begin
            cdb_valid  <= 1'b1;
            cdb_tag    <= alu_head.tag;
            cdb_data   <= alu_head.data;
            cdb_src    <= CDB_SRC_ALU;
            last_grant <= CDB_SRC_ALU;
        end else if (grant_ld) begin
            cdb_valid  <= 1'b1;
            cdb_tag    <= ld_head.tag;
            cdb_data   <= ld_head.data;
            cdb_src    <= CDB_SRC_LD;
            last_grant <= CDB_SRC_LD;
        end else begin
            cdb_valid  <= 1'b0;
        end
    end

    // Sticky record of any result dropped against a full FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (!bus.flush && ((bus.alu_valid && alu_full) || (bus.ld_valid && ld_full))) begin
            overflow_err <= 1'b1;
        end
    end

    assign bus.alu_full     = alu_full;
    assign bus.ld_full      = ld_full;
    assign bus.cdb_valid    = cdb_valid;
    assign bus.cdb_tag      = cdb_tag;
    assign bus.cdb_data     = cdb_data;
    assign bus.cdb_src      = cdb_src;
    assign bus.overflow_err = overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed, table-driven self-checking bench for cdb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter_if bus ();

    cdb_arbiter #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        av;
        logic [6:0]  at;
        logic [31:0] ad;
        logic        lv;
        logic [6:0]  lt;
        logic [31:0] ldd;
        logic        chk;
        logic        ev;
        logic [6:0]  et;
        logic [31:0] ed;
        logic        es;
        logic        eaf;
        logic        elf;
        logic        eov;
    } vec_t;

    vec_t vecs [40];
    int   nvec = 0;

    function automatic logic [31:0] adat(input int t);
        return 32'hA000_0000 | 32'(t);
    endfunction

    function automatic logic [31:0] ldat(input int t);
        return 32'hB000_0000 | 32'(t);
    endfunction

    task automatic add(input logic r, input logic f, input logic av, input int at,
                       input logic lv, input int lt, input logic chk, input logic ev,
                       input int et, input logic [31:0] ed, input logic es,
                       input logic eaf, input logic elf, input logic eov);
        vecs[nvec].rst_n = r;   vecs[nvec].flush = f;
        vecs[nvec].av = av;     vecs[nvec].at = 7'(at); vecs[nvec].ad = adat(at);
        vecs[nvec].lv = lv;     vecs[nvec].lt = 7'(lt); vecs[nvec].ldd = ldat(lt);
        vecs[nvec].chk = chk;   vecs[nvec].ev = ev;     vecs[nvec].et = 7'(et);
        vecs[nvec].ed = ed;     vecs[nvec].es = es;
        vecs[nvec].eaf = eaf;   vecs[nvec].elf = elf;   vecs[nvec].eov = eov;
        nvec++;
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic av, input logic [6:0] at,
                         input logic [31:0] ad, input logic lv, input logic [6:0] lt,
                         input logic [31:0] ldd);
        rst_n = r; bus.flush = f;
        bus.alu_valid = av; bus.alu_tag = at; bus.alu_result = ad;
        bus.ld_valid = lv;  bus.ld_tag = lt;  bus.ld_data = ldd;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        logic seen;
        drive(1'b0, 1'b0, 1'b1, 7'd5, 32'h1234, 1'b1, 7'd6, 32'h5678);

        // reset with activity on the inputs
        add(0,0,1,5,1,6,    0,0,0,0,0,0,0,0);
        add(0,0,1,9,1,10,   1,0,0,0,0,0,0,0);
        // single ALU push, broadcast exactly two cycles later
        add(1,0,1,3,0,0,    1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,1,3,32'hDEADBEEF,0,0,0,0);
        add(1,0,0,0,0,0,    1,0,3,32'hDEADBEEF,0,0,0,0);
        // reset, then simultaneous push: ALU wins the first tie
        add(0,0,0,0,0,0,    1,0,3,32'hDEADBEEF,0,0,0,0);
        add(1,0,1,1,1,2,    1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,1,1,adat(1),0,0,0,0);
        add(1,0,0,0,0,0,    1,1,2,ldat(2),1,0,0,0);
        add(1,0,0,0,0,0,    1,0,2,ldat(2),1,0,0,0);
        // both sources push every cycle: alternating grants, fill, overflow
        add(1,0,1,16,1,32,  1,0,2,ldat(2),1,0,0,0);
        add(1,0,1,17,1,33,  1,0,2,ldat(2),1,0,0,0);
        add(1,0,1,18,1,34,  1,1,16,adat(16),0,0,0,0);
        add(1,0,1,19,1,35,  1,1,32,ldat(32),1,0,0,0);
        add(1,0,1,20,1,36,  1,1,17,adat(17),0,0,0,0);
        add(1,0,1,21,1,37,  1,1,33,ldat(33),1,0,0,0);
        add(1,0,1,22,1,38,  1,1,18,adat(18),0,0,1,0);
        add(1,0,1,23,1,39,  1,1,34,ldat(34),1,1,0,1);
        // mid-operation reset with overflow set and LD FIFO full
        add(0,0,0,0,0,0,    1,1,19,adat(19),0,0,1,1);
        add(1,0,1,40,1,41,  1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,1,40,adat(40),0,0,0,0);
        add(1,0,0,0,0,0,    1,1,41,ldat(41),1,0,0,0);
        // build 3 ALU + 2 LD backlog, flush with pushes, then fresh push
        add(1,0,1,50,1,60,  1,0,41,ldat(41),1,0,0,0);
        add(1,0,1,51,1,61,  1,0,41,ldat(41),1,0,0,0);
        add(1,0,1,52,0,0,   1,1,50,adat(50),0,0,0,0);
        add(1,0,1,53,1,62,  1,1,60,ldat(60),1,0,0,0);
        add(1,0,1,54,1,63,  1,1,51,adat(51),0,0,0,0);
        add(1,1,1,55,1,64,  1,1,61,ldat(61),1,0,0,0);
        add(1,0,0,0,0,0,    1,0,0,0,0,0,0,0);
        add(1,0,1,70,0,0,   1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,    1,1,70,adat(70),0,0,0,0);
        add(1,0,0,0,0,0,    1,0,70,adat(70),0,0,0,0);
        vecs[2].ad = 32'hDEADBEEF;

        for (int i = 0; i < nvec; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].av, vecs[i].at, vecs[i].ad,
                  vecs[i].lv, vecs[i].lt, vecs[i].ldd);
            if (vecs[i].chk) begin
                check("cdb_valid", i, 32'(bus.cdb_valid),    32'(vecs[i].ev));
                check("cdb_tag",   i, 32'(bus.cdb_tag),      32'(vecs[i].et));
                check("cdb_data",  i, bus.cdb_data,          vecs[i].ed);
                check("cdb_src",   i, 32'(bus.cdb_src),      32'(vecs[i].es));
                check("alu_full",  i, 32'(bus.alu_full),     32'(vecs[i].eaf));
                check("ld_full",   i, 32'(bus.ld_full),      32'(vecs[i].elf));
                check("overflow",  i, 32'(bus.overflow_err), 32'(vecs[i].eov));
            end
        end

        // Lone load push: measure push-to-broadcast latency with a bound
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd99, ldat(99));
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 8) begin
            @(posedge clk); #1;
            idle();
            cnt++;
            seen = bus.cdb_valid;
        end
        check("ld_latency", 100, 32'(cnt),         32'd2);
        check("ld_tag",     100, 32'(bus.cdb_tag), 32'd99);
        check("ld_src",     100, 32'(bus.cdb_src), 32'(CDB_SRC_LD));

        // Flush while a grant is pending: nothing queued ever reaches the bus
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 7'd100, adat(100), 1'b1, 7'd101, ldat(101));
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 7'd102, adat(102), 1'b1, 7'd103, ldat(103));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            idle();
            check("flush_valid", 200 + k, 32'(bus.cdb_valid), 32'd0);
            check("flush_afull", 200 + k, 32'(bus.alu_full),  32'd0);
            check("flush_lfull", 200 + k, 32'(bus.ld_full),   32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
